// File: rtl/textconsole_pkg.sv
// Shared constants and FSM state encoding for the text-buffer console.
package textconsole_pkg;

   localparam logic [7:0] CC_BS        = 8'h08;
   localparam logic [7:0] CC_LF        = 8'h0A;
   localparam logic [7:0] CC_FF        = 8'h0C;
   localparam logic [7:0] CC_CR        = 8'h0D;
   localparam logic [7:0] CC_BLANK     = 8'h20;
   localparam logic [7:0] DEFAULT_ATTR = 8'h0F;

   typedef enum logic [3:0] {
      IDLE,
      DECODE,
      PUT_C,
      PUT_A,
      SCR_RC,
      SCR_WC,
      SCR_RA,
      SCR_WA,
      CLR_C,
      CLR_A
   } state_t;

endpackage

// File: rtl/textbuffer_console_ctrl.sv
// Byte-stream console: places glyphs at a cursor, handles CR/LF/BS/FF,
// and scrolls or clears the text buffer through its CPU port.
module textbuffer_console_ctrl
   import textconsole_pkg::*;
#(
   parameter int WIDTH  = 20,
   parameter int HEIGHT = 15,
   parameter int ADDR_W = 10,
   localparam int COL_W = $clog2(WIDTH),
   localparam int ROW_W = $clog2(HEIGHT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic [7:0]        in_attr,
   output logic              in_ready,
   output logic              tb_cs,
   output logic              tb_rw,
   output logic [ADDR_W-1:0] tb_addr,
   output logic [7:0]        tb_di,
   input  logic [7:0]        tb_dout,
   output logic [COL_W-1:0]  cur_col,
   output logic [ROW_W-1:0]  cur_row,
   output logic              busy
);

   localparam int POS_W = $clog2(WIDTH * HEIGHT);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
   localparam logic [POS_W-1:0]  W_P       = POS_W'(WIDTH);
   localparam logic [POS_W-1:0]  CELL_LAST = POS_W'(WIDTH * HEIGHT - 1);
   localparam logic [POS_W-1:0]  LAST_ROW  = POS_W'(WIDTH * (HEIGHT - 1));
   localparam logic [ADDR_W-1:0] ATTR_BASE = ADDR_W'(1) << (ADDR_W - 1);

   state_t            state, state_n;
   logic [POS_W-1:0]  idx, idx_n, pos;
   logic [7:0]        data_q, attr_q;
   logic              cs_n, rw_n, copy_n, copy_q, busy_n;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        di_n, di_q;
   logic              at_end;

   assign in_ready = (state == IDLE);
   assign at_end   = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
   // Copy cycles forward the previous cycle's read data straight to the buffer.
   assign tb_di    = copy_q ? tb_dout : di_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         IDLE:
            if (in_valid) state_n = DECODE;
         DECODE: begin
            state_n = IDLE;
            if (data_q >= CC_BLANK) begin
               state_n = PUT_C;
            end else if (data_q == CC_LF && cur_row == ROW_LAST) begin
               state_n = SCR_RC;
               idx_n   = W_P;
            end else if (data_q == CC_FF) begin
               state_n = CLR_C;
               idx_n   = '0;
            end
         end
         PUT_C: state_n = PUT_A;
         PUT_A: begin
            state_n = IDLE;
            if (at_end) begin
               state_n = SCR_RC;
               idx_n   = W_P;
            end
         end
         SCR_RC: state_n = SCR_WC;
         SCR_WC: state_n = SCR_RA;
         SCR_RA: state_n = SCR_WA;
         SCR_WA: begin
            state_n = SCR_RC;
            idx_n   = idx + 1'b1;
            if (idx == CELL_LAST) begin
               state_n = CLR_C;
               idx_n   = LAST_ROW;
            end
         end
         CLR_C: state_n = CLR_A;
         CLR_A: begin
            state_n = CLR_C;
            idx_n   = idx + 1'b1;
            if (idx == CELL_LAST) begin
               state_n = IDLE;
               idx_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cs_n   = 1'b0;
      rw_n   = 1'b0;
      addr_n = '0;
      di_n   = '0;
      copy_n = 1'b0;
      busy_n = 1'b0;
      case (state_n)
         PUT_C: begin
            cs_n = 1'b1; rw_n = 1'b1;
            addr_n = ADDR_W'(pos);
            di_n = data_q;
         end
         PUT_A: begin
            cs_n = 1'b1; rw_n = 1'b1;
            addr_n = ATTR_BASE | ADDR_W'(pos);
            di_n = attr_q;
         end
         SCR_RC: begin
            cs_n = 1'b1; busy_n = 1'b1;
            addr_n = ADDR_W'(idx_n);
         end
         SCR_WC: begin
            cs_n = 1'b1; rw_n = 1'b1; copy_n = 1'b1; busy_n = 1'b1;
            addr_n = ADDR_W'(idx_n - W_P);
         end
         SCR_RA: begin
            cs_n = 1'b1; busy_n = 1'b1;
            addr_n = ATTR_BASE | ADDR_W'(idx_n);
         end
         SCR_WA: begin
            cs_n = 1'b1; rw_n = 1'b1; copy_n = 1'b1; busy_n = 1'b1;
            addr_n = ATTR_BASE | ADDR_W'(idx_n - W_P);
         end
         CLR_C: begin
            cs_n = 1'b1; rw_n = 1'b1; busy_n = 1'b1;
            addr_n = ADDR_W'(idx_n);
            di_n = CC_BLANK;
         end
         CLR_A: begin
            cs_n = 1'b1; rw_n = 1'b1; busy_n = 1'b1;
            addr_n = ATTR_BASE | ADDR_W'(idx_n);
            di_n = attr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tb_cs   <= 1'b0;
         tb_rw   <= 1'b0;
         tb_addr <= '0;
         di_q    <= '0;
         copy_q  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         tb_cs   <= cs_n;
         tb_rw   <= rw_n;
         tb_addr <= addr_n;
         di_q    <= di_n;
         copy_q  <= copy_n;
         busy    <= busy_n;
      end
   end

   // Cursor keeps row*WIDTH+col in pos, updated by small steps only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         attr_q  <= DEFAULT_ATTR;
         pos     <= '0;
         cur_col <= '0;
         cur_row <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            data_q <= in_data;
            attr_q <= in_attr;
         end
         if (state == DECODE) begin
            case (data_q)
               CC_BS:
                  if (cur_col != '0) begin
                     cur_col <= cur_col - 1'b1;
                     pos     <= pos - 1'b1;
                  end
               CC_CR: begin
                  cur_col <= '0;
                  pos     <= pos - POS_W'(cur_col);
               end
               CC_LF: begin
                  cur_col <= '0;
                  if (cur_row != ROW_LAST) begin
                     cur_row <= cur_row + 1'b1;
                     pos     <= pos - POS_W'(cur_col) + W_P;
                  end else begin
                     pos     <= pos - POS_W'(cur_col);
                  end
               end
               CC_FF: begin
                  cur_col <= '0;
                  cur_row <= '0;
                  pos     <= '0;
               end
               default: ;
            endcase
         end
         if (state == PUT_A) begin
            if (cur_col != COL_LAST) begin
               cur_col <= cur_col + 1'b1;
               pos     <= pos + 1'b1;
            end else begin
               cur_col <= '0;
               if (cur_row != ROW_LAST) begin
                  cur_row <= cur_row + 1'b1;
                  pos     <= pos + 1'b1;
               end else begin
                  pos     <= LAST_ROW;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_textbuffer_console_ctrl.sv
// Directed bench for textbuffer_console_ctrl with a behavioural
// 1K x 8 text-buffer model behind the CPU port.
module tb_textbuffer_console_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] in_attr;
   logic       in_ready;
   logic       tb_cs;
   logic       tb_rw;
   logic [9:0] tb_addr;
   logic [7:0] tb_di;
   logic [7:0] tb_dout;
   logic [4:0] cur_col;
   logic [3:0] cur_row;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:1023];
   int         wlog[$];

   always #5 clk = ~clk;

   textbuffer_console_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_attr  (in_attr),
      .in_ready (in_ready),
      .tb_cs    (tb_cs),
      .tb_rw    (tb_rw),
      .tb_addr  (tb_addr),
      .tb_di    (tb_di),
      .tb_dout  (tb_dout),
      .cur_col  (cur_col),
      .cur_row  (cur_row),
      .busy     (busy)
   );

   always @(posedge clk) begin
      if (tb_cs && !tb_rw) tb_dout <= mem[tb_addr];
      if (tb_cs && tb_rw) begin
         mem[tb_addr] = tb_di;
         wlog.push_back(int'(tb_addr));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a,
                       output int low, output int bsy);
      int g;
      g = 0;
      while (!in_ready && g < 5000) begin
         g++;
         @(negedge clk);
      end
      in_data  = d;
      in_attr  = a;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      low = 0;
      bsy = 0;
      while (!in_ready && low < 3000) begin
         low++;
         if (busy) bsy++;
         @(negedge clk);
      end
   endtask

   initial begin
      int low, bsy, errs, wc;
      logic [7:0] ec, ea;
      for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
      tb_dout  = 8'h00;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_attr  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 1);
      chk("rst_cs", tb_cs, 0);
      chk("rst_rw", tb_rw, 0);
      chk("rst_addr", tb_addr, 0);
      chk("rst_di", tb_di, 0);
      chk("rst_col", cur_col, 0);
      chk("rst_row", cur_row, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);

      wlog.delete();
      send(8'h41, 8'h1E, low, bsy);
      chk("a_low", low, 3);
      chk("a_char", mem[0], 8'h41);
      chk("a_attr", mem[512], 8'h1E);
      chk("a_col", cur_col, 1);
      chk("a_row", cur_row, 0);
      chk("a_nwr", wlog.size(), 2);
      chk("a_addr0", wlog[0], 0);
      chk("a_addr1", wlog[1], 512);

      send(8'h0D, 8'h1E, low, bsy);
      chk("cr0_col", cur_col, 0);
      wlog.delete();
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         send(8'h78, 8'h1E, low, bsy);
         if (low != 3) errs++;
      end
      chk("x_rate", errs, 0);
      chk("x_col", cur_col, 0);
      chk("x_row", cur_row, 1);
      chk("x_nwr", wlog.size(), 40);
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         if (wlog[2*k] != k) errs++;
         if (wlog[2*k+1] != 512 + k) errs++;
      end
      chk("x_addrs", errs, 0);
      chk("x_char19", mem[19], 8'h78);
      chk("x_attr19", mem[531], 8'h1E);

      for (int k = 0; k < 13; k++) send(8'h0A, 8'h1E, low, bsy);
      chk("lf_low", low, 1);
      chk("lf_row", cur_row, 14);
      for (int k = 0; k < 19; k++) send(8'h79, 8'h1E, low, bsy);
      chk("y_col", cur_col, 19);
      chk("y_row", cur_row, 14);
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++) begin
            mem[r*20+c]     = 8'(r);
            mem[512+r*20+c] = 8'(8'h30 + r);
         end
      wlog.delete();
      send(8'h5A, 8'h4B, low, bsy);
      chk("z_wr_addr", wlog[0], 299);
      chk("z_nwr", wlog.size(), 602);
      chk("z_low", low, 1163);
      chk("z_busy", bsy, 1160);
      chk("z_col", cur_col, 0);
      chk("z_row", cur_row, 14);
      chk("z_moved", mem[279], 8'h5A);
      chk("z_moved_a", mem[791], 8'h4B);
      errs = 0;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++) begin
            if (r == 14) begin
               ec = 8'h20; ea = 8'h4B;
            end else if (r == 13 && c == 19) begin
               ec = 8'h5A; ea = 8'h4B;
            end else begin
               ec = 8'(r + 1); ea = 8'(8'h31 + r);
            end
            if (mem[r*20+c] !== ec) errs++;
            if (mem[512+r*20+c] !== ea) errs++;
         end
      chk("scroll_cells", errs, 0);

      wlog.delete();
      send(8'h0C, 8'h2C, low, bsy);
      chk("ff_low", low, 601);
      chk("ff_busy", bsy, 600);
      chk("ff_nwr", wlog.size(), 600);
      chk("ff_col", cur_col, 0);
      chk("ff_row", cur_row, 0);
      errs = 0;
      for (int i = 0; i < 300; i++) begin
         if (mem[i] !== 8'h20) errs++;
         if (mem[512+i] !== 8'h2C) errs++;
      end
      chk("ff_cells", errs, 0);

      wc = wlog.size();
      send(8'h08, 8'h2C, low, bsy);
      chk("bs0_low", low, 1);
      chk("bs0_col", cur_col, 0);
      chk("bs0_row", cur_row, 0);
      chk("bs0_nwr", wlog.size(), wc);

      for (int k = 0; k < 3; k++) send(8'h0A, 8'h2C, low, bsy);
      for (int k = 0; k < 7; k++) send(8'h71, 8'h2C, low, bsy);
      chk("q_col", cur_col, 7);
      chk("q_row", cur_row, 3);
      chk("q_char", mem[66], 8'h71);
      send(8'h0D, 8'h2C, low, bsy);
      chk("cr_col", cur_col, 0);
      chk("cr_row", cur_row, 3);
      send(8'h71, 8'h2C, low, bsy);
      send(8'h71, 8'h2C, low, bsy);
      wc = wlog.size();
      send(8'h08, 8'h2C, low, bsy);
      chk("bs_col", cur_col, 1);
      chk("bs_nwr", wlog.size(), wc);
      send(8'h07, 8'h2C, low, bsy);
      chk("bel_low", low, 1);
      chk("bel_nwr", wlog.size(), wc);
      chk("bel_col", cur_col, 1);

      for (int k = 0; k < 11; k++) send(8'h0A, 8'h2C, low, bsy);
      chk("pre_row", cur_row, 14);
      in_data  = 8'h0A;
      in_attr  = 8'h2C;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_cs", tb_cs, 1);
      reset = 1'b1;
      #1;
      chk("arst_cs", tb_cs, 0);
      chk("arst_col", cur_col, 0);
      chk("arst_row", cur_row, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      wlog.delete();
      send(8'h42, 8'h5A, low, bsy);
      chk("b_low", low, 3);
      chk("b_addr0", wlog[0], 0);
      chk("b_char", mem[0], 8'h42);
      chk("b_attr", mem[512], 8'h5A);
      chk("b_col", cur_col, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
